// File: rtl/clkdiv_pkg.sv
// Shared definitions for the programmable clock divider bank.
// Contents:
//   DefaultWidth / DefaultDivisor - default counter width and post-reset divisor
//   chan_state_e                  - per-channel IDLE/RUN state
//   high_count()                  - number of high cycles in a period of length d
package clkdiv_pkg;

  localparam int unsigned DefaultWidth   = 16;
  localparam int unsigned DefaultDivisor = 20;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } chan_state_e;

  // High phase is ceil(d/2) cycles, so odd divisors spend the extra cycle high.
  function automatic int unsigned high_count(input int unsigned d);
    return d - (d >> 1);
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: IDLE/RUN FSM, phase counter, active and pending divisor.
// Ports:
//   clk_i   - system clock, rising edge
//   rst_i   - asynchronous active-high reset
//   en_i    - run request, sampled at start and at every period boundary
//   load_i  - one-cycle divisor load strobe
//   div_i   - divisor value captured when load_i is high
//   clk_o   - registered divided clock
//   tick_o  - registered one-cycle pulse in the first cycle of each period
//   busy_o  - channel is in RUN
// Width must not exceed 32 because the high-count helper works on 32-bit values.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int unsigned Width      = DefaultWidth,
  parameter int unsigned DefaultDiv = DefaultDivisor
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [Width-1:0] div_i,
  output logic             clk_o,
  output logic             tick_o,
  output logic             busy_o
);

  chan_state_e      state_q, state_d;
  logic [Width-1:0] d_q, d_d;
  logic [Width-1:0] p_q, p_d;
  logic             pv_q, pv_d;
  logic [Width-1:0] cnt_q, cnt_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;

  logic [Width-1:0] dn;
  logic             boundary;
  logic             run_d;

  always_comb begin
    // Divisor that would govern a period starting at this edge.
    dn       = load_i ? div_i : (pv_q ? p_q : d_q);
    boundary = (cnt_q == d_q - Width'(1));

    state_d = state_q;
    d_d     = d_q;
    p_d     = p_q;
    pv_d    = pv_q;
    cnt_d   = cnt_q;

    if (load_i) begin
      p_d  = div_i;
      pv_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        // Nothing to protect while idle, so a load lands in D directly.
        if (load_i) begin
          d_d  = div_i;
          pv_d = 1'b0;
        end
        if (en_i && (dn != '0)) begin
          state_d = ST_RUN;
          d_d     = dn;
          pv_d    = 1'b0;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (boundary) begin
          // Pending (or same-edge) load is applied whether we continue or stop.
          cnt_d = '0;
          d_d   = dn;
          pv_d  = 1'b0;
          if (!(en_i && (dn != '0))) begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + Width'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered from next state so they line up with cnt_q.
    run_d  = (state_d == ST_RUN);
    clk_d  = run_d && (cnt_d < Width'(high_count(32'(d_d))));
    tick_d = run_d && (cnt_d == '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      d_q     <= Width'(DefaultDiv);
      p_q     <= '0;
      pv_q    <= 1'b0;
      cnt_q   <= '0;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      p_q     <= p_d;
      pv_q    <= pv_d;
      cnt_q   <= cnt_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
    end
  end

  assign clk_o  = clk_q;
  assign tick_o = tick_q;
  assign busy_o = (state_q == ST_RUN);

endmodule

// File: rtl/clk_divider_bank.sv
// Bank of independent programmable clock dividers sharing one system clock.
// Ports:
//   I_CLK  - system clock, rising edge
//   rst    - asynchronous active-high reset
//   I_EN   - per-channel run request
//   I_LOAD - per-channel one-cycle divisor load strobe
//   I_DIV  - packed divisors, channel k at [k*WIDTH +: WIDTH]
//   O_CLK  - per-channel registered divided clock
//   O_TICK - per-channel registered start-of-period pulse
//   O_BUSY - per-channel RUN indication
module clk_divider_bank
  import clkdiv_pkg::*;
#(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned WIDTH       = DefaultWidth,
  parameter int unsigned DEFAULT_DIV = DefaultDivisor
) (
  input  logic                      I_CLK,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       I_EN,
  input  logic [CHANNELS-1:0]       I_LOAD,
  input  logic [CHANNELS*WIDTH-1:0] I_DIV,
  output logic [CHANNELS-1:0]       O_CLK,
  output logic [CHANNELS-1:0]       O_TICK,
  output logic [CHANNELS-1:0]       O_BUSY
);

  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    clkdiv_channel #(
      .Width      (WIDTH),
      .DefaultDiv (DEFAULT_DIV)
    ) u_chan (
      .clk_i  (I_CLK),
      .rst_i  (rst),
      .en_i   (I_EN[k]),
      .load_i (I_LOAD[k]),
      .div_i  (I_DIV[k*WIDTH +: WIDTH]),
      .clk_o  (O_CLK[k]),
      .tick_o (O_TICK[k]),
      .busy_o (O_BUSY[k])
    );
  end

endmodule

// File: tb/tb_clk_divider_bank.sv
module tb_clk_divider_bank;

  logic        I_CLK = 1'b0;
  logic        rst;
  logic [3:0]  I_EN;
  logic [3:0]  I_LOAD;
  logic [63:0] I_DIV;
  logic [3:0]  O_CLK;
  logic [3:0]  O_TICK;
  logic [3:0]  O_BUSY;

  clk_divider_bank #(
    .CHANNELS    (4),
    .WIDTH       (16),
    .DEFAULT_DIV (20)
  ) dut (
    .I_CLK  (I_CLK),
    .rst    (rst),
    .I_EN   (I_EN),
    .I_LOAD (I_LOAD),
    .I_DIV  (I_DIV),
    .O_CLK  (O_CLK),
    .O_TICK (O_TICK),
    .O_BUSY (O_BUSY)
  );

  always #5 I_CLK = ~I_CLK;

  typedef struct {
    int         due;
    logic [3:0] c;
    logic [3:0] t;
    logic [3:0] b;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   cyc_n  = 0;
  int   n_chk  = 0;
  int   n_pass = 0;

  // Staged inputs, applied at the next falling edge.
  logic        rst_s;
  logic [3:0]  en_s;
  logic [3:0]  ld_s;
  logic [63:0] div_s;

  always @(posedge I_CLK) cyc_n <= cyc_n + 1;

  // Monitor: pops every expectation that falls due at this falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge I_CLK);
      while (sb.size() > 0 && sb[0].due <= cyc_n) begin
        e = sb.pop_front();
        n_chk++;
        if (O_CLK !== e.c || O_TICK !== e.t || O_BUSY !== e.b) begin
          $display("FAIL %s @%0d: clk=%b tick=%b busy=%b, expected clk=%b tick=%b busy=%b",
                   e.nm, cyc_n, O_CLK, O_TICK, O_BUSY, e.c, e.t, e.b);
        end else begin
          n_pass++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", n_pass, n_chk);
    $fatal(1);
  end

  // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
  task automatic cyc(input logic [3:0] ec, input logic [3:0] et, input logic [3:0] eb,
                     input string nm);
    exp_t e;
    @(negedge I_CLK);
    rst    = rst_s;
    I_EN   = en_s;
    I_LOAD = ld_s;
    I_DIV  = div_s;
    ld_s   = '0;
    e.due  = cyc_n + 1;
    e.c    = ec;
    e.t    = et;
    e.b    = eb;
    e.nm   = nm;
    sb.push_back(e);
  endtask

  task automatic cyc0(input logic c, input logic t, input logic b, input string nm);
    cyc({3'b000, c}, {3'b000, t}, {3'b000, b}, nm);
  endtask

  task automatic load0(input int unsigned d);
    div_s[15:0] = 16'(d);
    ld_s[0]     = 1'b1;
  endtask

  // Channel 0 running: patterns given MSB first.
  task automatic pat0(input logic [31:0] cp, input logic [31:0] tp, input int n,
                      input string nm);
    for (int i = 0; i < n; i++) begin
      cyc0(cp[n-1-i], tp[n-1-i], 1'b1, nm);
    end
  endtask

  task automatic run0(input int d, input int hi, input int first, input int n,
                      input string nm);
    for (int i = first; i < first + n; i++) begin
      cyc0(logic'((i % d) < hi), logic'((i % d) == 0), 1'b1, nm);
    end
  endtask

  // Assert reset a little after the rising edge that ends this cycle.
  task automatic cyc_rst_mid(input string nm);
    cyc(4'b0000, 4'b0000, 4'b0000, nm);
    @(posedge I_CLK);
    #2;
    rst   = 1'b1;
    rst_s = 1'b1;
  endtask

  initial begin
    logic [23:0] cpat;
    logic [23:0] tpat;
    logic [3:0]  ec;
    logic [3:0]  et;
    int          w;

    rst    = 1'b1;
    I_EN   = '0;
    I_LOAD = '0;
    I_DIV  = '0;
    rst_s  = 1'b1;
    en_s   = '0;
    ld_s   = '0;
    div_s  = '0;

    // Reset default divisor of 20, pending load lost on mid-period reset.
    repeat (3) cyc0(1'b0, 1'b0, 1'b0, "reset");
    rst_s = 1'b0;
    repeat (2) cyc0(1'b0, 1'b0, 1'b0, "idle");
    en_s = 4'b0001;
    run0(20, 10, 0, 42, "div20");
    load0(7);
    repeat (3) cyc0(1'b1, 1'b0, 1'b1, "div20 pend");
    cyc_rst_mid("rst mid high");
    cyc0(1'b0, 1'b0, 1'b0, "rst hold");
    rst_s = 1'b0;
    run0(20, 10, 0, 21, "div20 after rst");
    en_s = 4'b0000;
    run0(20, 10, 21, 19, "div20 stopping");
    cyc0(1'b0, 1'b0, 1'b0, "div20 stopped");

    // Odd divisor, then D=1 and D=2 loaded on boundaries.
    load0(5);
    cyc0(1'b0, 1'b0, 1'b0, "load5 idle");
    en_s = 4'b0001;
    pat0(32'b1110011100, 32'b1000010000, 10, "div5");
    load0(1);
    pat0(32'b111111, 32'b111111, 6, "div1");
    load0(2);
    pat0(32'b101010, 32'b101010, 6, "div2");
    en_s = 4'b0000;
    cyc0(1'b0, 1'b0, 1'b0, "div2 stop");

    // Deferred reload mid-period and bypass reload at the boundary.
    load0(6);
    cyc0(1'b0, 1'b0, 1'b0, "load6 idle");
    en_s = 4'b0001;
    cpat = 24'b111000_110_110_111000_110_110;
    tpat = 24'b100000_100_100_100000_100_100;
    for (int i = 0; i < 24; i++) begin
      if (i == 3)  load0(3);
      if (i == 10) load0(6);
      if (i == 18) load0(3);
      cyc0(cpat[23-i], tpat[23-i], 1'b1, "reload");
    end
    en_s = 4'b0000;
    cyc0(1'b0, 1'b0, 1'b0, "reload stop");

    // Stop requested early in the period still completes 4 high + 4 low.
    load0(8);
    cyc0(1'b0, 1'b0, 1'b0, "load8 idle");
    en_s = 4'b0001;
    pat0(32'b11, 32'b10, 2, "div8");
    en_s = 4'b0000;
    pat0(32'b110000, 32'b000000, 6, "div8 draining");
    repeat (3) cyc0(1'b0, 1'b0, 1'b0, "div8 no tick");

    // Zero divisor stops at boundary and blocks restart until a nonzero load.
    load0(4);
    cyc0(1'b0, 1'b0, 1'b0, "load4 idle");
    en_s = 4'b0001;
    pat0(32'b1100, 32'b1000, 4, "div4");
    cyc0(1'b1, 1'b1, 1'b1, "div4");
    load0(0);
    pat0(32'b100, 32'b000, 3, "div4 load0");
    repeat (3) cyc0(1'b0, 1'b0, 1'b0, "zero idle");
    load0(4);
    pat0(32'b1100, 32'b1000, 4, "reload4");
    en_s = 4'b0000;
    cyc0(1'b0, 1'b0, 1'b0, "div4 stop");

    // Independent channels: 2, 3, 7, 65535 started together.
    div_s = {16'd65535, 16'd7, 16'd3, 16'd2};
    ld_s  = 4'b1111;
    cyc(4'b0000, 4'b0000, 4'b0000, "load all");
    en_s = 4'b1111;
    for (int i = 0; i < 120; i++) begin
      ec[0] = (i % 2) < 1;
      et[0] = (i % 2) == 0;
      ec[1] = (i % 3) < 2;
      et[1] = (i % 3) == 0;
      ec[2] = (i % 7) < 4;
      et[2] = (i % 7) == 0;
      ec[3] = 1'b1;
      et[3] = (i == 0);
      cyc(ec, et, 4'b1111, "multi");
    end

    w = 0;
    while (sb.size() != 0 && w < 5) begin
      @(negedge I_CLK);
      #1;
      w++;
    end
    if (sb.size() != 0) begin
      n_chk++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/clk_divider_bank.md
# clk_divider_bank

Multi-channel programmable clock divider: the parametrised successor to the team's fixed-N divider. Each channel derives a divided clock and a one-cycle tick from the single system clock. Divisors are reloadable at runtime, odd divisors are supported, and channels start and stop without glitches. The block sits between the board clock and slow consumers such as display scanning, debouncers and UART baud generation.

## Interface
Clock is I_CLK. Reset is rst: asynchronous, active-high.

Parameters:
- CHANNELS, 4: number of independent divider channels.
- WIDTH, 16: divisor and counter width; maximum divisor is 2^WIDTH-1.
- DEFAULT_DIV, 20: active divisor of every channel after reset.

Ports:
- I_CLK  in  1  system clock; all logic is on its rising edge.
- rst  in  1  asynchronous active-high reset.
- I_EN  in  CHANNELS  per-channel run request.
- I_LOAD  in  CHANNELS  per-channel divisor load strobe, one cycle.
- I_DIV  in  CHANNELS*WIDTH  divisor values; channel k uses bits [k*WIDTH +: WIDTH].
- O_CLK  out  CHANNELS  divided clocks, registered.
- O_TICK  out  CHANNELS  one-cycle pulse at the start of each period, registered.
- O_BUSY  out  CHANNELS  channel is in RUN.

## Operation
Each channel holds the following state: active divisor D, pending divisor P with valid flag PV, phase counter cnt (WIDTH bits), and state IDLE or RUN.

Reset (asynchronous, immediate):
- D=DEFAULT_DIV, PV=0, cnt=0, state IDLE.
- O_CLK=0, O_TICK=0, O_BUSY=0.

Load:
- At an edge where I_LOAD[k]=1, P<=I_DIV slice and PV<=1.
- Repeated loads before they are applied: the last one wins.
- In IDLE, the loaded value is copied to D at the same edge and PV stays 0.
- In RUN, D changes only at a period boundary, so a period in progress is never reshaped.

Effective next divisor Dn:
- I_DIV slice if I_LOAD[k]=1 at this edge.
- Otherwise P if PV=1.
- Otherwise D.

IDLE to RUN:
- Transition at an edge where I_EN[k]=1 and Dn!=0.
- At that edge D<=Dn, PV<=0, cnt<=0.

RUN, counting:
- cnt increments each edge until it reaches D-1.
- At cnt==D-1 the edge is a boundary.

Period boundary, sampled at the edge:
- If I_EN[k]=1 and Dn!=0: D<=Dn, PV<=0, cnt<=0, stay in RUN.
- Otherwise: go to IDLE, cnt<=0, and apply a pending load to D.

Outputs, as registered values during a cycle:
- O_CLK=1 in RUN while cnt < D-(D>>1), i.e. high for ceil(D/2) cycles and low for floor(D/2). Duty is exactly 50% for even D.
- O_TICK=1 in RUN while cnt==0.
- O_BUSY=1 in RUN.
- In IDLE: O_CLK=0, O_TICK=0, O_BUSY=0.

Divisor cases:
- D=1: O_CLK and O_TICK are constantly 1 while running.
- Divisor 0: never enters RUN; if it becomes Dn at a boundary, the channel stops there.
- All channels are fully independent.

## Timing
- Start latency: I_EN rises before edge E. O_CLK, O_TICK and O_BUSY are 1 in the cycle after E.
- Period: exactly D I_CLK cycles, edge to edge.
- Ticks are D cycles apart and coincide with each O_CLK rising edge.
- Stop: dropping I_EN mid-period has no effect until the boundary, so the last high and low phases complete in full. O_BUSY falls in the cycle after the boundary edge.
- Load during a boundary cycle: the I_LOAD and boundary edge coincide, and the new D governs the very next period (bypass).
- Reset mid-period: outputs go to 0 at once, and any pending load is discarded.

## Structure
- Package clkdiv_pkg holds:
  - the WIDTH and DEFAULT_DIV defaults;
  - the channel state enum (ST_IDLE, ST_RUN);
  - a function computing the high count D-(D>>1).
- Sub-module clkdiv_channel implements one channel (IDLE/RUN FSM, counter, pending register).
- clk_divider_bank instantiates CHANNELS copies in a generate loop and slices I_DIV.

## Test plan
- Reset default: CHANNELS=1, release rst, I_EN=1. O_TICK pulses every 20 cycles and O_CLK is high for 10 of them. With rst asserted mid-high, O_CLK=0 in the same cycle.
- Odd divisor: load 5 while idle, then enable. O_CLK pattern is 1,1,1,0,0 repeating. D=1 gives a constant 1; D=2 gives 1,0.
- Deferred reload: run with D=6, then load 3 at cnt==2. The current period finishes at 6 cycles and the following periods are 3. A load at cnt==5 takes effect immediately at that boundary.
- Glitch-free stop: with D=8, drop I_EN at cnt==1. O_CLK completes 4 high and 4 low cycles, then O_BUSY=0. No tick follows.
- Zero divisor: load 0 while running with D=4. The channel stops at the boundary, and re-asserting I_EN keeps it idle until a nonzero load.
- Independence: 4 channels with divisors 2, 3, 7 and 65535, all enabled on the same edge. Every channel shows the correct period, and ticks coincide at cycle 0 only.
